// File: rtl/af_ctrl_pkg.sv
// ============================================================================
//  Module   : af_ctrl_pkg
//  Brief    : State encoding and activation-type check for af_drain_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`include "sys_defs.svh"

package af_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_CLEAR  = 2'd3
    } af_ctrl_state_t;

    // Only the pass-through and ReLU functions exist in the AF array.
    function automatic logic af_type_valid(input logic [1:0] af_type);
        return (af_type == `AF_NONE) || (af_type == `AF_RELU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sys_defs.svh
// Shared system definitions: activation-function codes and output tile geometry.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define AF_NONE       2'b00
`define AF_RELU       2'b01
`define AF_SIGMOID    2'b10
`define AF_RESERVED   2'b11

`define OUTPUT_HEIGHT 4
`define OUTPUT_WIDTH  2
`define OUT_BIN_LEN   8

`endif

// File: rtl/af_drain_ctrl.sv
// ============================================================================
//  Module   : af_drain_ctrl
//  Brief    : Sequences AF-array enable, row-by-row tile drain and buffer clear.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`include "sys_defs.svh"

module af_drain_ctrl
    import af_ctrl_pkg::*;
#(
    parameter int H  = `OUTPUT_HEIGHT,
    parameter int W  = `OUTPUT_WIDTH,
    parameter int DW = `OUT_BIN_LEN
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             compute_done,
    input  logic [1:0]                       af_type_in,
    input  logic [H-1:0][W-1:0][DW-1:0]      af_outputs,
    output logic                             af_finish,
    output logic [1:0]                       af_type,
    output logic [W-1:0][DW-1:0]             out_data,
    output logic [$clog2(H)-1:0]             out_row,
    output logic                             out_last,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             buffer_clear,
    output logic                             busy,
    output logic                             done,
    output logic                             cfg_err,
    output logic                             overrun
);

    localparam int RW = $clog2(H);
    localparam logic [RW-1:0] c_LAST_ROW = RW'(H - 1);

    af_ctrl_state_t          state_q, state_d;
    logic [1:0]              af_type_q, af_type_d;
    logic [W-1:0][DW-1:0]    out_data_q, out_data_d;
    logic [RW-1:0]           out_row_q, out_row_d;
    logic                    out_last_q, out_last_d;
    logic                    out_valid_q, out_valid_d;
    logic                    af_finish_q, af_finish_d;
    logic                    clear_q, clear_d;
    logic                    busy_q, busy_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    overrun_q, overrun_d;
    logic [RW-1:0]           w_row_inc;

    assign w_row_inc = out_row_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        af_type_d  = af_type_q;
        out_data_d = out_data_q;
        out_row_d  = out_row_q;
        cfg_err_d  = 1'b0;
        overrun_d  = compute_done && (state_q != ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (compute_done) begin
                    af_type_d = af_type_in;
                    if (af_type_valid(af_type_in)) begin
                        state_d   = ST_SETTLE;
                        out_row_d = '0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                out_data_d = af_outputs[0];
                out_row_d  = '0;
                state_d    = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (out_row_q == c_LAST_ROW) begin
                        state_d = ST_CLEAR;
                    end else begin
                        out_data_d = af_outputs[w_row_inc];
                        out_row_d  = w_row_inc;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every port is a flop.
        af_finish_d = (state_d == ST_SETTLE) || (state_d == ST_DRAIN);
        out_valid_d = (state_d == ST_DRAIN);
        out_last_d  = out_valid_d && (out_row_d == c_LAST_ROW);
        busy_d      = (state_d != ST_IDLE);
        clear_d     = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            af_type_q   <= `AF_NONE;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            af_finish_q <= 1'b0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            af_type_q   <= af_type_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            af_finish_q <= af_finish_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
            cfg_err_q   <= cfg_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign af_finish    = af_finish_q;
    assign af_type      = af_type_q;
    assign out_data     = out_data_q;
    assign out_row      = out_row_q;
    assign out_last     = out_last_q;
    assign out_valid    = out_valid_q;
    assign buffer_clear = clear_q;
    assign busy         = busy_q;
    assign done         = clear_q;
    assign cfg_err      = cfg_err_q;
    assign overrun      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_af_drain_ctrl.sv
// ============================================================================
//  Module   : tb_af_drain_ctrl
//  Brief    : Vector table plus row scoreboard for af_drain_ctrl, H=4 W=2 DW=8.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_af_drain_ctrl;

    localparam int H  = 4;
    localparam int W  = 2;
    localparam int DW = 8;
    localparam logic [1:0] T_NONE = 2'b00;
    localparam logic [1:0] T_RELU = 2'b01;

    // {valid, last, af_finish, busy, done/clear, cfg_err, overrun}
    localparam logic [6:0] E_IDLE   = 7'b0000000;
    localparam logic [6:0] E_SETTLE = 7'b0011000;
    localparam logic [6:0] E_DRAIN  = 7'b1011000;
    localparam logic [6:0] E_DLAST  = 7'b1111000;
    localparam logic [6:0] E_CLEAR  = 7'b0001100;
    localparam logic [6:0] E_ERR    = 7'b0000010;
    localparam logic [6:0] E_OVR    = 7'b0000001;

    typedef logic [W-1:0][DW-1:0]        row_t;
    typedef logic [H-1:0][W-1:0][DW-1:0] tile_t;

    typedef struct {
        logic       cd;
        logic [1:0] ty;
        logic       rdy;
        logic       st;
        logic [6:0] e;
        int         ts;
    } vec_t;

    typedef struct {
        row_t          data;
        logic [1:0]    row;
        logic          last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        compute_done;
    logic [1:0]  af_type_in;
    tile_t       af_outputs;
    logic        af_finish;
    logic [1:0]  af_type;
    row_t        out_data;
    logic [1:0]  out_row;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        buffer_clear;
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        overrun;

    tile_t       tile_drv;
    tile_t       tiles [2];
    vec_t        vecs [$];
    beat_t       exp_q [$];
    int          checks;
    int          errors;

    af_drain_ctrl #(.H(H), .W(W), .DW(DW)) dut (
        .clock        (clk),
        .reset        (rst),
        .compute_done (compute_done),
        .af_type_in   (af_type_in),
        .af_outputs   (af_outputs),
        .af_finish    (af_finish),
        .af_type      (af_type),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .buffer_clear (buffer_clear),
        .busy         (busy),
        .done         (done),
        .cfg_err      (cfg_err),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic row_t act_row(input tile_t t, input int r, input logic [1:0] ty);
        row_t res;
        for (int c = 0; c < W; c++) begin
            res[c] = t[r][c];
            if (ty == T_RELU && t[r][c][DW-1]) res[c] = '0;
        end
        return res;
    endfunction

    // Stand-in for the AF array: output only while enabled, using the DUT's type.
    always_comb begin
        af_outputs = '0;
        if (af_finish) begin
            for (int r = 0; r < H; r++) af_outputs[r] = act_row(tile_drv, r, af_type);
        end
    end

    function automatic vec_t mk(input logic cd, input logic [1:0] ty, input logic rdy,
                                input logic st, input logic [6:0] e, input int ts);
        vec_t v;
        v.cd = cd; v.ty = ty; v.rdy = rdy; v.st = st; v.e = e; v.ts = ts;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_af_finish"}, 32'(af_finish), 32'd0);
        chk({tag, "_af_type"}, 32'(af_type), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_out_row"}, 32'(out_row), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_buffer_clear"}, 32'(buffer_clear), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    task automatic apply(input vec_t x, input int idx);
        beat_t b;
        compute_done = x.cd;
        af_type_in   = x.ty;
        out_ready    = x.rdy;
        tile_drv     = tiles[x.ts];
        if (x.st) begin
            for (int r = 0; r < H; r++) begin
                b.data = act_row(tiles[x.ts], r, x.ty);
                b.row  = 2'(r);
                b.last = (r == H - 1);
                exp_q.push_back(b);
            end
        end
        @(negedge clk);
        chk($sformatf("out_valid[%0d]", idx),    32'(out_valid),    32'(x.e[6]));
        chk($sformatf("out_last[%0d]", idx),     32'(out_last),     32'(x.e[5]));
        chk($sformatf("af_finish[%0d]", idx),    32'(af_finish),    32'(x.e[4]));
        chk($sformatf("busy[%0d]", idx),         32'(busy),         32'(x.e[3]));
        chk($sformatf("done[%0d]", idx),         32'(done),         32'(x.e[2]));
        chk($sformatf("buffer_clear[%0d]", idx), 32'(buffer_clear), 32'(x.e[2]));
        chk($sformatf("cfg_err[%0d]", idx),      32'(cfg_err),      32'(x.e[1]));
        chk($sformatf("overrun[%0d]", idx),      32'(overrun),      32'(x.e[0]));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk($sformatf("beat_unexpected[%0d]", idx), 32'd1, 32'd0);
            end else begin
                b = exp_q.pop_front();
                chk($sformatf("beat_data[%0d]", idx), 32'(out_data), 32'(b.data));
                chk($sformatf("beat_row[%0d]", idx),  32'(out_row),  32'(b.row));
                chk($sformatf("beat_last[%0d]", idx), 32'(out_last), 32'(b.last));
            end
        end else if (out_valid && exp_q.size() != 0) begin
            chk($sformatf("hold_data[%0d]", idx), 32'(out_data), 32'(exp_q[0].data));
            chk($sformatf("hold_row[%0d]", idx),  32'(out_row),  32'(exp_q[0].row));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        tiles[0][0][0] = 8'hFF; tiles[0][0][1] = 8'd5;
        tiles[0][1][0] = 8'd3;  tiles[0][1][1] = 8'hFE;
        tiles[0][2][0] = 8'd0;  tiles[0][2][1] = 8'd7;
        tiles[0][3][0] = 8'hF8; tiles[0][3][1] = 8'd1;
        tiles[1][0][0] = 8'd10; tiles[1][0][1] = 8'hEC;
        tiles[1][1][0] = 8'd30; tiles[1][1][1] = 8'd40;
        tiles[1][2][0] = 8'hCE; tiles[1][2][1] = 8'd60;
        tiles[1][3][0] = 8'd70; tiles[1][3][1] = 8'hB0;

        // ReLU drain with ready held high
        vecs.push_back(mk(1'b1, T_RELU, 1'b1, 1'b1, E_IDLE, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_SETTLE, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DRAIN, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DLAST, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_CLEAR, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_IDLE, 0));
        // Invalid activation type
        vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, E_IDLE, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_ERR, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_IDLE, 0));
        // Backpressure in cycles 2-4, pass-through type
        vecs.push_back(mk(1'b1, T_NONE, 1'b1, 1'b1, E_IDLE, 1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_SETTLE, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, E_DRAIN, 1));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DRAIN, 1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DLAST, 1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_CLEAR, 1));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_IDLE, 1));
        // Overrun mid-drain and in the CLEAR cycle
        vecs.push_back(mk(1'b1, T_RELU, 1'b1, 1'b1, E_IDLE, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_SETTLE, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DRAIN, 0));
        vecs.push_back(mk(1'b1, 2'b11, 1'b1, 1'b0, E_DRAIN, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DRAIN | E_OVR, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DLAST, 0));
        vecs.push_back(mk(1'b1, T_RELU, 1'b1, 1'b0, E_CLEAR, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_IDLE | E_OVR, 0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 1'b0, E_IDLE, 0));

        rst          = 1'b1;
        compute_done = 1'b0;
        af_type_in   = 2'b00;
        out_ready    = 1'b0;
        tile_drv     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i], i);
        chk("sb_empty_table", 32'(exp_q.size()), 32'd0);

        // Reset asserted during DRAIN aborts the tile
        apply(mk(1'b1, T_RELU, 1'b1, 1'b1, E_IDLE, 0), 100);
        apply(mk(1'b0, 2'b00, 1'b1, 1'b0, E_SETTLE, 0), 101);
        apply(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DRAIN, 0), 102);
        compute_done = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        exp_q.delete();
        @(negedge clk);
        chk("rst_hold_done", 32'(done), 32'd0);
        chk("rst_hold_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Restart after reset must begin at row 0
        apply(mk(1'b1, T_NONE, 1'b1, 1'b1, E_IDLE, 1), 110);
        apply(mk(1'b0, 2'b00, 1'b1, 1'b0, E_SETTLE, 1), 111);
        for (int i = 0; i < 3; i++) apply(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DRAIN, 1), 112 + i);
        apply(mk(1'b0, 2'b00, 1'b1, 1'b0, E_DLAST, 1), 115);
        apply(mk(1'b0, 2'b00, 1'b1, 1'b0, E_CLEAR, 1), 116);
        apply(mk(1'b0, 2'b00, 1'b1, 1'b0, E_IDLE, 1), 117);
        chk("sb_empty_final", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
